// File: rtl/mux_gate_sched.sv
// mux_gate_sched
//   Two-requester bitwise gate engine. Every result bit comes out of a single
//   shared 2:1 mux (out = sel ? d1 : d0). Each cycle evaluates one mux pass on
//   one bit. Two-pass ops keep the first pass in an intermediate bit t.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   req_valid/ready    per-requester handshake (bit i = requester i)
//   req_op/a/b         per-requester opcode and operands
//                      (op 0 AND, 1 OR, 2 NOT, 3 NAND, 4 NOR, 5 XOR, 6 XNOR,
//                       7 reserved)
//   rsp_valid/ready    result handshake
//   rsp_id/data/err    owning requester, result word, reserved-op flag
//   busy               high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for a request; the round-robin winner sees req_ready
// EVAL1 | first mux pass on bit k (the final pass for AND/OR/NOT)
// EVAL2 | second mux pass on bit k for NAND/NOR/XOR/XNOR
// RESP  | result held; rsp_valid comes up one cycle after entry
module mux_gate_sched #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][2:0]       req_op,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EVAL1, EVAL2, RESP} state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [KW-1:0]   k;
    logic            t_q;
    logic            last_grant;

    logic            grant_id;
    logic            two_pass;
    logic            a_bit;
    logic            b_bit;
    logic            sel;
    logic            d1;
    logic            d0;
    logic            mux_out;
    logic            accept;

    // On a tie, the requester that did not win last time gets the grant.
    // last_grant resets to 1, so requester 0 wins the first tie.
    always_comb begin
        grant_id = 1'b0;
        case (req_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (!rst && state == IDLE && req_valid != 2'b00)
            req_ready = grant_id ? 2'b10 : 2'b01;
    end

    assign accept   = |(req_valid & req_ready);
    assign two_pass = (op_q >= 3'd3) && (op_q <= 3'd6);
    assign a_bit    = a_q[k];
    assign b_bit    = b_q[k];

    // Mux input routing for each op and pass.
    always_comb begin
        sel = 1'b0;
        d1  = 1'b0;
        d0  = 1'b0;
        case (op_q)
            3'd0: begin sel = b_bit; d1 = a_bit; d0 = 1'b0;  end
            3'd1: begin sel = a_bit; d1 = 1'b1;  d0 = b_bit; end
            3'd2: begin sel = a_bit; d1 = 1'b0;  d0 = 1'b1;  end
            3'd3: begin
                if (state == EVAL2) begin sel = t_q;   d1 = 1'b0;  d0 = 1'b1; end
                else                begin sel = b_bit; d1 = a_bit; d0 = 1'b0; end
            end
            3'd4: begin
                if (state == EVAL2) begin sel = t_q;   d1 = 1'b0;  d0 = 1'b1;  end
                else                begin sel = a_bit; d1 = 1'b1;  d0 = b_bit; end
            end
            3'd5: begin
                if (state == EVAL2) begin sel = b_bit; d1 = t_q;   d0 = a_bit; end
                else                begin sel = a_bit; d1 = 1'b0;  d0 = 1'b1;  end
            end
            3'd6: begin
                if (state == EVAL2) begin sel = b_bit; d1 = a_bit; d0 = t_q;  end
                else                begin sel = a_bit; d1 = 1'b0;  d0 = 1'b1; end
            end
            default: begin sel = 1'b0; d1 = 1'b0; d0 = 1'b0; end
        endcase
        mux_out = sel ? d1 : d0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            k          <= '0;
            t_q        <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= req_op[grant_id];
                        a_q        <= req_a[grant_id];
                        b_q        <= req_b[grant_id];
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        k          <= '0;
                        rsp_data   <= '0;
                        rsp_err    <= (req_op[grant_id] == 3'd7);
                        busy       <= 1'b1;
                        state      <= (req_op[grant_id] == 3'd7) ? RESP : EVAL1;
                    end
                end
                EVAL1: begin
                    if (two_pass) begin
                        t_q   <= mux_out;
                        state <= EVAL2;
                    end else begin
                        rsp_data[k] <= mux_out;
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= RESP;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                EVAL2: begin
                    rsp_data[k] <= mux_out;
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= RESP;
                    end else begin
                        k     <= k + 1'b1;
                        state <= EVAL1;
                    end
                end
                RESP: begin
                    // rsp_valid comes up on the first RESP cycle. This gives
                    // the T+1 / T+1+WIDTH / T+1+2*WIDTH latencies.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_gate_sched.sv
// tb_mux_gate_sched
//   Self-checking bench for mux_gate_sched (WIDTH=8). Expected responses come
//   from a behavioural operator model. They are queued when a request is
//   accepted and popped when rsp_valid appears.
module tb_mux_gate_sched;
    localparam int W  = 8;
    localparam int W2 = 2 * W;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][2:0]   req_op;
    logic [1:0][W-1:0] req_a;
    logic [1:0][W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mux_gate_sched #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op);
        if (op == 3'd7) return 1;
        if (op <= 3'd2) return W + 1;
        return 2 * W + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.id   = id;
        e.data = model(op, a, b);
        e.err  = (op == 3'd7);
        e.lat  = model_lat(op);
        sb.push_back(e);
    endtask

    // Raises one requester and waits for the grant. The task returns 1 ns
    // after the accept edge. The requester inputs are then scrambled, and
    // the result must not depend on them.
    task automatic issue(input int id, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output bit ok);
        ok         = 1'b0;
        req_op[id] = op;
        req_a[id]  = a;
        req_b[id]  = b;
        req_valid  = 2'b01 << id;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (req_ready[id]) begin
                push_exp(id[0], op, a, b);
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        req_valid = 2'b00;
        req_op    = 6'($urandom);
        req_a     = W2'($urandom);
        req_b     = W2'($urandom);
    endtask

    task automatic await_rsp(output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            lat++;
            if (rsp_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        step();
        step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        tests++; if (rsp_data !== 8'h00) begin fails++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
        tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        rst       = 1'b0;
        req_valid = 2'b00;
        step();
    endtask

    typedef struct {
        int         id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } stim_t;

    task automatic test_ops();
        stim_t tbl[$];
        bit    ok;
        bit    to;
        int    lat;
        exp_t  e;
        tbl.push_back('{0, 3'd0, 8'hF0, 8'h3C});
        tbl.push_back('{1, 3'd5, 8'hA5, 8'hFF});
        tbl.push_back('{1, 3'd3, 8'hFF, 8'h0F});
        tbl.push_back('{0, 3'd4, 8'h00, 8'h01});
        tbl.push_back('{1, 3'd6, 8'hA5, 8'hFF});
        tbl.push_back('{0, 3'd2, 8'h0F, 8'h33});
        tbl.push_back('{1, 3'd1, 8'h81, 8'h18});
        tbl.push_back('{0, 3'd7, 8'h12, 8'h34});
        for (int i = 0; i < 6; i++)
            tbl.push_back('{int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                            8'($urandom), 8'($urandom)});
        foreach (tbl[n]) begin
            issue(tbl[n].id, tbl[n].op, tbl[n].a, tbl[n].b, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL ops_accept entry %0d got no grant want grant", n);
                continue;
            end
            await_rsp(lat, to);
            e = sb.pop_front();
            tests++;
            if (to) begin
                fails++;
                $display("FAIL ops_timeout entry %0d got no rsp_valid want rsp_valid", n);
                continue;
            end
            if (lat != e.lat) begin fails++; $display("FAIL ops_latency entry %0d got %0d want %0d", n, lat, e.lat); end
            tests++; if (rsp_data !== e.data) begin fails++; $display("FAIL ops_data entry %0d op %0d got %h want %h", n, tbl[n].op, rsp_data, e.data); end
            tests++; if (rsp_id !== e.id) begin fails++; $display("FAIL ops_id entry %0d got %b want %b", n, rsp_id, e.id); end
            tests++; if (rsp_err !== e.err) begin fails++; $display("FAIL ops_err entry %0d got %b want %b", n, rsp_err, e.err); end
            step();
        end
    endtask

    task automatic test_round_robin();
        bit   got;
        bit   to;
        int   lat;
        exp_t e;
        logic [1:0] want;
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_op[0] = 3'd1; req_a[0] = 8'h01; req_b[0] = 8'h02;
        req_op[1] = 3'd1; req_a[1] = 8'h10; req_b[1] = 8'h20;
        req_valid = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0;
            for (int i = 0; i < 60; i++) begin
                if (req_ready !== 2'b00) begin got = 1'b1; break; end
                step();
            end
            want = 2'b01 << (n % 2);
            tests++; if (req_ready === 2'b11) begin fails++; $display("FAIL rr_onehot grant %0d got %b want one-hot", n, req_ready); end
            tests++;
            if (!got || req_ready !== want) begin
                fails++;
                $display("FAIL rr_grant grant %0d got %b want %b", n, req_ready, want);
                break;
            end
            push_exp(want[1], 3'd1, req_a[n % 2], req_b[n % 2]);
            step();
            await_rsp(lat, to);
            e = sb.pop_front();
            tests++;
            if (to) begin fails++; $display("FAIL rr_timeout grant %0d got no rsp_valid want rsp_valid", n); break; end
            if (rsp_id !== e.id) begin fails++; $display("FAIL rr_id grant %0d got %b want %b", n, rsp_id, e.id); end
            tests++; if (rsp_data !== e.data) begin fails++; $display("FAIL rr_data grant %0d got %h want %h", n, rsp_data, e.data); end
            step();
        end
        req_valid = 2'b00;
        sb.delete();
    endtask

    task automatic test_backpressure();
        bit   ok;
        bit   to;
        int   lat;
        exp_t e;
        rsp_ready = 1'b0;
        issue(0, 3'd0, 8'hC3, 8'h5A, ok);
        await_rsp(lat, to);
        e = sb.pop_front();
        tests++;
        if (!ok || to) begin
            fails++;
            $display("FAIL bp_start got ok=%b timeout=%b want ok=1 timeout=0", ok, to);
        end else begin
            for (int c = 0; c < 5; c++) begin
                req_valid = 2'b11;
                #1;
                tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cycle %0d got %b want 1", c, rsp_valid); end
                tests++; if (rsp_data !== e.data) begin fails++; $display("FAIL bp_data cycle %0d got %h want %h", c, rsp_data, e.data); end
                tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_req_ready cycle %0d got %b want 00", c, req_ready); end
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy cycle %0d got %b want 1", c, busy); end
                step();
            end
            req_valid = 2'b00;
            rsp_ready = 1'b1;
            step();
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_release_busy got %b want 0", busy); end
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got %b want 0", rsp_valid); end
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        bit   ok;
        bit   to;
        int   lat;
        exp_t e;
        // XOR from requester 0, so last_grant is 0 if it survives the reset.
        issue(0, 3'd5, 8'hA5, 8'hFF, ok);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", rsp_valid); end
        req_op[0] = 3'd0; req_a[0] = 8'hF0; req_b[0] = 8'h3C;
        req_op[1] = 3'd0; req_a[1] = 8'h0F; req_b[1] = 8'hFF;
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL rstmid_tie got %b want 01", req_ready);
        end else begin
            push_exp(1'b0, 3'd0, 8'hF0, 8'h3C);
            step();
            req_valid = 2'b00;
            await_rsp(lat, to);
            e = sb.pop_front();
            tests++;
            if (to) begin
                fails++;
                $display("FAIL rstmid_timeout got no rsp_valid want rsp_valid");
            end else begin
                if (rsp_data !== e.data) begin fails++; $display("FAIL rstmid_data got %h want %h", rsp_data, e.data); end
                tests++; if (rsp_id !== e.id) begin fails++; $display("FAIL rstmid_id got %b want %b", rsp_id, e.id); end
                tests++; if (lat != e.lat) begin fails++; $display("FAIL rstmid_latency got %0d want %0d", lat, e.lat); end
            end
            step();
        end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux_gate_sched.md
MUX_GATE_SCHED -- requirements
Module: mux_gate_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept; a request transfers when valid[i]&ready[i].
REQ-007 req_op  input  2x3  per-requester opcode: 0 AND, 1 OR, 2 NOT, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
REQ-008 req_a, req_b  input  2xWIDTH each  per-requester operands.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_data  output  WIDTH  result word.
REQ-013 rsp_err  output  1  high when the accepted opcode was reserved.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL compute all gate results through one shared 2:1 mux (out = sel ? d1 : d0), evaluated once per cycle on one bit; no other logic SHALL produce result bits.
REQ-016 FSM states SHALL be IDLE, EVAL1, EVAL2 and RESP.
REQ-017 IDLE: the granted requester's req_ready SHALL be 1 (combinational from req_valid), all others 0; req_ready SHALL be 0 in every other state.
REQ-018 Arbitration SHALL be round-robin: with a single valid requester, that requester is granted; with both valid, the requester not granted last is granted; after reset, requester 0 wins the first tie.
REQ-019 On accept, the block SHALL latch op, a, b and id, clear bit index k to 0, and go to EVAL1; a reserved op SHALL go directly to RESP with rsp_data=0 and rsp_err=1.
REQ-020 Single-pass ops, EVAL1 only, per bit k: AND sel=b[k],d1=a[k],d0=0; OR sel=a[k],d1=1,d0=b[k]; NOT sel=a[k],d1=0,d0=1 (b ignored).
REQ-021 Two-pass ops, EVAL1 then EVAL2 per bit, with intermediate t stored in EVAL1:
- NAND: t = b?a:0, then out = t?0:1.
- NOR: t = a?1:b, then out = t?0:1.
- XOR: t = a?0:1, then out = b?t:a.
- XNOR: t = a?0:1, then out = b?a:t.
REQ-022 Bits SHALL be processed LSB first, with the result bit written to result[k] on the final pass of bit k and k incremented afterwards; after bit WIDTH-1 completes, the FSM SHALL go to RESP.
REQ-023 Latency from the accept edge T SHALL be:
- single-pass op: rsp_valid rises at T+1+WIDTH;
- two-pass op: rsp_valid rises at T+1+2*WIDTH;
- reserved op: rsp_valid rises at T+1.
REQ-024 RESP: rsp_valid=1 and rsp_data/rsp_id/rsp_err SHALL stay stable until rsp_ready=1, then the FSM SHALL return to IDLE the next cycle; no request is accepted in the same cycle as rsp_ready.
REQ-025 Requester inputs SHALL be ignored after accept; changes to them during EVAL SHALL NOT affect the result.
REQ-026 The round-robin pointer SHALL update only on accept.

Reset
REQ-027 While rst=1, including mid-EVAL or mid-RESP, the block SHALL go to IDLE and discard the operation in flight.
REQ-028 Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, k=0; the round-robin pointer SHALL give requester 0 priority.
REQ-029 req_ready SHALL be 0 while rst=1.

Verification (WIDTH=8)
REQ-030 Req0 AND a=0xF0 b=0x3C, rsp_ready=1 -> rsp_valid 9 cycles after accept, rsp_data=0x30, rsp_id=0, rsp_err=0.
REQ-031 Req1 XOR a=0xA5 b=0xFF -> rsp_valid 17 cycles after accept, rsp_data=0x5A, rsp_id=1. Repeat with NAND a=0xFF b=0x0F -> 0xF0; NOR a=0x00 b=0x01 -> 0xFE; XNOR a=0xA5 b=0xFF -> 0xA5; NOT a=0x0F -> 0xF0; OR a=0x81 b=0x18 -> 0x99.
REQ-032 Both requesters valid with op OR after reset, held valid -> grants 0,1,0,1 in order; req_ready is never 2'b11.
REQ-033 rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_data stay stable, req_ready=0, busy=1; rsp_ready pulse -> IDLE next cycle.
REQ-034 rst pulsed at bit 3 of an XOR -> next cycle busy=0, rsp_valid=0; a fresh AND completes correctly; a tie grants requester 0.
REQ-035 op=7 -> rsp_valid at T+1, rsp_err=1, rsp_data=0x00.
